// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory and holds the IF/ID register presented to decode.
//
// state  | meaning
// S_FILL | no valid word on imem_rdata yet; issue first read, emit a bubble
// S_RUN  | imem_rdata holds the word for fetch_pc; move it into IF/ID
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic [PC_W-1:0] inst_pc_plus1,
  output logic            inst_valid
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]     inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic [PC_W-1:0] inst_pc_plus1_q, inst_pc_plus1_d;
  logic            inst_valid_q, inst_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_FILL;
      pc_q            <= RESET_PC;
      fetch_pc_q      <= RESET_PC;
      inst_q          <= 16'h0000;
      inst_pc_q       <= '0;
      inst_pc_plus1_q <= '0;
      inst_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_pc_q      <= fetch_pc_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_pc_plus1_q <= inst_pc_plus1_d;
      inst_valid_q    <= inst_valid_d;
    end
  end

  // Memory output is only advanced when the IF/ID register will consume it,
  // so a stall keeps imem_rdata paired with fetch_pc.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fetch_pc_d      = fetch_pc_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_pc_plus1_d = inst_pc_plus1_q;
    inst_valid_d    = inst_valid_q;
    imem_rd_en      = 1'b0;

    if (rst) begin
      imem_rd_en = 1'b0;
    end else if (br_taken) begin
      pc_d         = br_target;
      inst_d       = 16'h0000;
      inst_valid_d = 1'b0;
      state_d      = S_FILL;
    end else if (!stall) begin
      imem_rd_en = 1'b1;
      fetch_pc_d = pc_q;
      pc_d       = pc_q + PC_ONE;
      case (state_q)
        S_FILL: begin
          inst_d       = 16'h0000;
          inst_valid_d = 1'b0;
          state_d      = S_RUN;
        end
        S_RUN: begin
          inst_d          = imem_rdata;
          inst_pc_d       = fetch_pc_q;
          inst_pc_plus1_d = fetch_pc_q + PC_ONE;
          inst_valid_d    = 1'b1;
          state_d         = S_RUN;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  assign imem_addr     = pc_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus1 = inst_pc_plus1_q;
  assign inst_valid    = inst_valid_q;

endmodule
